cop_muldiv_unit: RTL and testbench

//  Parametrised multi-cycle multiply/divide coprocessor holding the HI/LO pair.

---
 rtl/cop_muldiv_unit.sv | 197 +++++++++++++++++++
 tb/tb_cop_muldiv_unit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cop_muldiv_unit.sv
// cop_muldiv_unit
// Multi-cycle multiply/divide coprocessor that owns the HI/LO register pair.
// Executes MULT, MULTU, MADD, MSUB, MSUBU, DIV and DIVU. Each one runs one
// shift-add or restoring-divide step per clock. The pipeline launches an
// operation with start/op and stalls while busy is high.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     launch request, only looked at while idle
//   op        000 MULT, 001 MADD, 010 MSUBU, 011 DIV, 100 MULTU,
//             101 DIVU, 110 MSUB, 111 NOP
//   rs, rt    operand A (multiplicand/dividend), operand B (multiplier/divisor)
//   hi_we     MTHI write enable (idle only)
//   lo_we     MTLO write enable (idle only)
//   wdata     MTHI/MTLO data
//   busy      operation in flight
//   done      one-cycle pulse, hi/lo carry the new result in that cycle
//   div_zero  pulses with done when a divide had rt == 0
//   hi, lo    HI and LO registers
module cop_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int DW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MADD  = 3'b001;
    localparam logic [2:0] OP_MSUBU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b101;
    localparam logic [2:0] OP_MSUB  = 3'b110;
    localparam logic [2:0] OP_NOP   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    state_t state, state_n;

    logic [2:0]       op_q;
    logic [WIDTH-1:0] opnd_q;
    logic [WIDTH-1:0] hi_w;
    logic [WIDTH-1:0] lo_w;
    logic             neg_q;
    logic             rem_neg_q;
    logic             dz_q;
    logic [CW-1:0]    cnt;

    // Decode of the operation being launched this cycle.
    logic             in_signed;
    logic             in_div;
    logic             rs_neg;
    logic             rt_neg;
    logic [WIDTH-1:0] rs_mag;
    logic [WIDTH-1:0] rt_mag;
    logic             start_ok;
    logic             is_div_q;
    logic             last_step;

    assign in_signed = (op == OP_MULT) || (op == OP_MADD) ||
                       (op == OP_MSUB) || (op == OP_DIV);
    assign in_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign rs_neg    = in_signed & rs[WIDTH-1];
    assign rt_neg    = in_signed & rt[WIDTH-1];
    assign rs_mag    = rs_neg ? -rs : rs;
    assign rt_mag    = rt_neg ? -rt : rt;
    assign start_ok  = (state == S_IDLE) && start && (op != OP_NOP);
    assign is_div_q  = (op_q == OP_DIV) || (op_q == OP_DIVU);
    assign last_step = (cnt == CW'(WIDTH - 1));
    assign busy      = (state != S_IDLE);

    // One iteration of either algorithm. Multiply keeps the partial product in
    // {hi_w, lo_w} with the multiplier shifting out of lo_w. Divide keeps the
    // partial remainder in hi_w while quotient bits shift into lo_w.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;

    assign mul_sum   = {1'b0, hi_w} + (lo_w[0] ? {1'b0, opnd_q} : '0);
    assign div_shift = {hi_w, lo_w[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, opnd_q});
    // The true difference is below 2^WIDTH whenever div_ge holds.
    assign div_diff  = div_shift[WIDTH-1:0] - opnd_q;

    // Sign fixup and accumulation. The remainder takes the sign of the dividend,
    // so a divide by zero naturally returns rs in HI.
    logic [DW-1:0]    prod;
    logic [DW-1:0]    p_fix;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic [DW-1:0]    res;

    assign prod  = {hi_w, lo_w};
    assign p_fix = neg_q ? -prod : prod;
    assign quot  = dz_q ? '1 : (neg_q ? -lo_w : lo_w);
    assign rem   = rem_neg_q ? -hi_w : hi_w;

    always_comb begin
        res = p_fix;
        case (op_q)
            OP_MADD:           res = {hi, lo} + p_fix;
            OP_MSUB, OP_MSUBU: res = {hi, lo} - p_fix;
            OP_DIV, OP_DIVU:   res = {rem, quot};
            default:           res = p_fix;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (start_ok) state_n = S_RUN;
            S_RUN:   if (last_step) state_n = S_FIN;
            S_FIN:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= '0;
            opnd_q    <= '0;
            hi_w      <= '0;
            lo_w      <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            cnt       <= '0;
            hi        <= '0;
            lo        <= '0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            done     <= (state == S_FIN);
            div_zero <= (state == S_FIN) && dz_q;
            case (state)
                S_IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start_ok) begin
                        op_q      <= op;
                        opnd_q    <= in_div ? rt_mag : rs_mag;
                        hi_w      <= '0;
                        lo_w      <= in_div ? rs_mag : rt_mag;
                        neg_q     <= rs_neg ^ rt_neg;
                        rem_neg_q <= rs_neg;
                        dz_q      <= in_div && (rt == '0);
                        cnt       <= '0;
                    end
                end
                S_RUN: begin
                    cnt <= cnt + 1'b1;
                    if (is_div_q) begin
                        hi_w <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                        lo_w <= {lo_w[WIDTH-2:0], div_ge};
                    end else begin
                        hi_w <= mul_sum[WIDTH:1];
                        lo_w <= {mul_sum[0], lo_w[WIDTH-1:1]};
                    end
                end
                S_FIN: begin
                    hi <= res[DW-1:WIDTH];
                    lo <= res[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cop_muldiv_unit.sv
// tb_cop_muldiv_unit
// Self-checking bench for cop_muldiv_unit (WIDTH=32). Operations are checked
// against a plain-arithmetic model of HI/LO using 64-bit integers.
module tb_cop_muldiv_unit;

    localparam int W = 32;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [2:0]    op;
    logic [W-1:0]  rs;
    logic [W-1:0]  rt;
    logic          hi_we;
    logic          lo_we;
    logic [W-1:0]  wdata;
    logic          busy;
    logic          done;
    logic          div_zero;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int checks   = 0;
    int failures = 0;

    // Reference HI/LO state and expected divide-by-zero flag.
    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;
    logic         m_dz;

    cop_muldiv_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .rs       (rs),
        .rt       (rt),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Updates the model from the operation's arithmetic definition.
    task automatic model_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0]     hilo;
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        longint          sq;
        longint          sr;
        longint unsigned uq;
        longint unsigned ur;
        hilo = {m_hi, m_lo};
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        ua   = {32'd0, a};
        ub   = {32'd0, b};
        m_dz = 1'b0;
        case (o)
            3'b000: hilo = sa * sb;
            3'b100: hilo = ua * ub;
            3'b001: hilo = hilo + sa * sb;
            3'b110: hilo = hilo - sa * sb;
            3'b010: hilo = hilo - ua * ub;
            3'b011: begin
                if (b == 0) begin
                    hilo = {a, 32'hFFFF_FFFF};
                    m_dz = 1'b1;
                end else begin
                    sq   = sa / sb;
                    sr   = sa % sb;
                    hilo = {sr[31:0], sq[31:0]};
                end
            end
            3'b101: begin
                if (b == 0) begin
                    hilo = {a, 32'hFFFF_FFFF};
                    m_dz = 1'b1;
                end else begin
                    uq   = ua / ub;
                    ur   = ua % ub;
                    hilo = {ur[31:0], uq[31:0]};
                end
            end
            default: ;
        endcase
        m_hi = hilo[63:32];
        m_lo = hilo[31:0];
    endtask

    // MTHI/MTLO while idle; entered and left 1 time unit after a rising edge.
    task automatic write_hilo(input logic whi, input logic wlo, input logic [W-1:0] wd);
        hi_we = whi;
        lo_we = wlo;
        wdata = wd;
        if (whi) m_hi = wd;
        if (wlo) m_lo = wd;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        lo_we = 1'b0;
        checkOutput("mt_hi", {32'd0, hi}, {32'd0, m_hi});
        checkOutput("mt_lo", {32'd0, lo}, {32'd0, m_lo});
    endtask

    // Launches one operation (optionally with an MTHI/MTLO in the start cycle),
    // optionally pokes start/hi_we/lo_we while busy, then checks timing and result.
    task automatic applyStimulus(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic whi, input logic wlo, input logic [W-1:0] wd,
                                 input bit inject);
        int lat;
        int busy_cycles;
        start = 1'b1;
        op    = o;
        rs    = a;
        rt    = b;
        hi_we = whi;
        lo_we = wlo;
        wdata = wd;
        if (whi) m_hi = wd;
        if (wlo) m_lo = wd;
        model_op(o, a, b);
        @(posedge clk);
        #1;
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        op    = 3'($urandom());
        rs    = $urandom();
        rt    = $urandom();
        lat   = 0;
        busy_cycles = 0;
        for (int k = 1; k <= W + 6; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            if (busy) busy_cycles++;
            if (inject && (k == 5 || k == 20)) begin
                start = 1'b1;
                op    = 3'b100;
                hi_we = 1'b1;
                lo_we = 1'b1;
                wdata = $urandom();
            end else begin
                start = 1'b0;
                hi_we = 1'b0;
                lo_we = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        checkOutput("done_latency", 64'(lat), 64'(W + 2));
        checkOutput("busy_cycles", 64'(busy_cycles), 64'(W + 1));
        checkOutput("busy_at_done", {63'd0, busy}, 64'd0);
        checkOutput("hi", {32'd0, hi}, {32'd0, m_hi});
        checkOutput("lo", {32'd0, lo}, {32'd0, m_lo});
        checkOutput("div_zero", {63'd0, div_zero}, {63'd0, m_dz});
    endtask

    function automatic logic [W-1:0] pick_val();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int done_seen;
        logic [2:0] ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst_n = 1'b0;
        start = 1'b0;
        op    = 3'b111;
        rs    = '0;
        rt    = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;
        m_hi  = '0;
        m_lo  = '0;
        m_dz  = 1'b0;

        #12;
        checkOutput("rst_hi", {32'd0, hi}, 64'd0);
        checkOutput("rst_lo", {32'd0, lo}, 64'd0);
        checkOutput("rst_busy", {63'd0, busy}, 64'd0);
        checkOutput("rst_done", {63'd0, done}, 64'd0);
        checkOutput("rst_div_zero", {63'd0, div_zero}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] directed operations");
        applyStimulus(3'b000, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("mult_neg_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
        checkOutput("mult_neg_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFEB);
        write_hilo(1'b1, 1'b0, 32'd0);
        write_hilo(1'b0, 1'b1, 32'd10);
        applyStimulus(3'b001, 32'd2, 32'd3, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("madd_lo", {32'd0, lo}, 64'd16);
        applyStimulus(3'b010, 32'd20, 32'd1, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("msubu_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFC);
        applyStimulus(3'b011, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(3'b101, 32'd7, 32'd0, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(3'b011, 32'hFFFF_FFF9, 32'd0, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(3'b110, 32'hFFFF_FFFE, 32'd9, 1'b0, 1'b1, 32'd5, 1'b0);
        applyStimulus(3'b000, 32'd12345, 32'hFFFF_0000, 1'b0, 1'b0, '0, 1'b1);

        $display("[TB] NOP start is ignored");
        start = 1'b1;
        op    = 3'b111;
        rs    = 32'd3;
        rt    = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("nop_busy", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;
        checkOutput("nop_done", {63'd0, done}, 64'd0);
        checkOutput("nop_lo", {32'd0, lo}, {32'd0, m_lo});

        $display("[TB] reset in the middle of an operation");
        write_hilo(1'b1, 1'b1, 32'hA5A5_5A5A);
        start = 1'b1;
        op    = 3'b000;
        rs    = 32'd1000;
        rt    = 32'd77;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        checkOutput("abort_hi", {32'd0, hi}, 64'd0);
        checkOutput("abort_lo", {32'd0, lo}, 64'd0);
        checkOutput("abort_busy", {63'd0, busy}, 64'd0);
        #2;
        rst_n = 1'b1;
        m_hi = '0;
        m_lo = '0;
        done_seen = 0;
        for (int k = 0; k < W + 6; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) done_seen++;
        end
        checkOutput("abort_no_done", 64'(done_seen), 64'd0);
        applyStimulus(3'b100, 32'd6, 32'd7, 1'b0, 1'b0, '0, 1'b0);

        $display("[TB] random operations");
        for (int i = 0; i < 60; i++) begin
            ro = 3'($urandom_range(0, 6));
            ra = pick_val();
            rb = pick_val();
            if ((ro == 3'b011 || ro == 3'b101) && $urandom_range(0, 5) == 0) rb = '0;
            applyStimulus(ro, ra, rb,
                          ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), $urandom(),
                          ($urandom_range(0, 4) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
